// File: rtl/elevator_pkg.sv
// Shared state encoding, direction constants and per-floor mask helpers for the elevator controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  function automatic logic onehot(input int idx, input int flr);
    return idx == flr;
  endfunction

  function automatic logic ahead(input int idx, input int flr, input logic up);
    return up ? (idx > flr) : (idx < flr);
  endfunction

  function automatic logic behind(input int idx, input int flr, input logic up);
    return up ? (idx < flr) : (idx > flr);
  endfunction

endpackage

// File: rtl/elevator_dispatch_timer.sv
// elev_timer: loadable down-counter with hold; done is the terminal-count (zero) compare.
module elev_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         hold,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)                    cnt <= '0;
    else if (load)                cnt <= load_val;
    else if (!hold && cnt != '0)  cnt <= cnt - W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/elevator_dispatch.sv
// Single-car SCAN dispatcher: latches calls, times travel and door dwell, drives one-hot door-open.
// Optional `ELEV_HOME_RETURN_EN: after IDLE_CYCLES idle clocks away from floor 0 the car returns there.
//  state | meaning
//  IDLE  | parked, door closed, waiting for a call
//  MOVE  | travelling one floor per MOVE_CYCLES clocks
//  DOOR  | door open at current floor for DOOR_CYCLES clocks
module elevator_dispatch
  import elevator_pkg::*;
#(
  parameter int NFLOORS     = 4,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3,
  parameter int IDLE_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NFLOORS-1:0]         intreq,
  input  logic [NFLOORS-1:0]         extreq,
  input  logic                       stop,
  output logic [NFLOORS-1:0]         open,
  output logic [$clog2(NFLOORS)-1:0] floor,
  output logic                       dir_up,
  output logic                       moving,
  output logic [NFLOORS-1:0]         pending
);

  localparam int FW   = $clog2(NFLOORS);
  localparam int CMAX = (MOVE_CYCLES > DOOR_CYCLES)
                        ? ((MOVE_CYCLES > IDLE_CYCLES) ? MOVE_CYCLES : IDLE_CYCLES)
                        : ((DOOR_CYCLES > IDLE_CYCLES) ? DOOR_CYCLES : IDLE_CYCLES);
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [FW-1:0] TOP     = FW'(NFLOORS - 1);
  localparam logic [CW-1:0] MV_LOAD = CW'(MOVE_CYCLES - 1);
  localparam logic [CW-1:0] DR_LOAD = CW'(DOOR_CYCLES - 1);

  state_t state, state_n;
  logic [FW-1:0]      floor_n;
  logic               dir_n;
  logic [NFLOORS-1:0] req, calls, scan, at_v, ahd_v, bhd_v, svc;
  logic               any_here, any_ahead, any_behind;
  logic               decide, restart, mv_done, dr_done, mv_load, dr_load;
  logic               home_act;

  always_comb begin
    req      = intreq | extreq;
    calls    = pending | req;
    scan     = calls;
    scan[0]  = calls[0] | home_act;
    state_n  = state;
    floor_n  = floor;
    dir_n    = dir_up;
    decide   = 1'b0;
    restart  = 1'b0;

    if (!stop && state == MOVE && mv_done) begin
      if (dir_up && floor != TOP)       floor_n = floor + FW'(1);
      else if (!dir_up && floor != '0)  floor_n = floor - FW'(1);
    end

    // Masks are taken at the floor the car will occupy after this edge.
    for (int i = 0; i < NFLOORS; i++) begin
      at_v[i]  = onehot(i, int'(floor_n));
      ahd_v[i] = ahead(i, int'(floor_n), dir_up);
      bhd_v[i] = behind(i, int'(floor_n), dir_up);
    end
    any_here   = |(calls & at_v);
    any_ahead  = |(scan & ahd_v);
    any_behind = |(scan & bhd_v);

    if (!stop) begin
      case (state)
        IDLE:    decide = 1'b1;
        MOVE:    decide = mv_done;
        DOOR: begin
          if (|(req & at_v)) restart = 1'b1;
          else               decide  = dr_done;
        end
        default: state_n = IDLE;
      endcase

      if (decide) begin
        if (any_here)        state_n = DOOR;
        else if (any_ahead)  state_n = MOVE;
        else if (any_behind) begin
          state_n = MOVE;
          dir_n   = ~dir_up;
        end
        else                 state_n = IDLE;
      end

      if (floor_n == '0)       dir_n = DIR_UP;
      else if (floor_n == TOP) dir_n = DIR_DN;
    end
  end

  assign svc     = (state_n == DOOR) ? at_v : '0;
  assign mv_load = !stop && (state_n == MOVE) && (state != MOVE || mv_done);
  assign dr_load = !stop && (state_n == DOOR) && (state != DOOR || restart);

  elev_timer #(.W(CW)) u_move (
    .clk(clk), .reset(reset), .load(mv_load), .load_val(MV_LOAD),
    .hold(stop || state != MOVE), .done(mv_done)
  );

  elev_timer #(.W(CW)) u_door (
    .clk(clk), .reset(reset), .load(dr_load), .load_val(DR_LOAD),
    .hold(stop || state != DOOR), .done(dr_done)
  );

`ifdef ELEV_HOME_RETURN_EN
  localparam logic [CW-1:0] ID_LOAD = CW'(IDLE_CYCLES - 1);
  logic homing, id_done, idle_qual;

  assign idle_qual = (state == IDLE) && (calls == '0) && (floor != '0);

  elev_timer #(.W(CW)) u_idle (
    .clk(clk), .reset(reset), .load(!stop && !idle_qual), .load_val(ID_LOAD),
    .hold(stop), .done(id_done)
  );

  // The home call only steers SCAN; it never appears on pending or opens the door.
  assign home_act = homing || (!stop && idle_qual && id_done);

  always_ff @(posedge clk) begin
    if (reset) homing <= 1'b0;
    else       homing <= home_act && (floor_n != '0);
  end
`else
  assign home_act = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      floor   <= '0;
      dir_up  <= DIR_UP;
      pending <= '0;
    end else begin
      state   <= state_n;
      floor   <= floor_n;
      dir_up  <= dir_n;
      pending <= (pending | req) & ~svc;
    end
  end

  always_comb begin
    open = '0;
    if (state == DOOR)
      for (int i = 0; i < NFLOORS; i++) open[i] = onehot(i, int'(floor));
  end

  assign moving = (state == MOVE);

endmodule

// File: tb/tb_elevator_dispatch.sv
// Self-checking bench for elevator_dispatch: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a floor-counting reference model.
module tb_elevator_dispatch;

  localparam int NF = 4;
  localparam int MV = 4;
  localparam int DR = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       stop = 1'b0;
  logic [3:0] intreq = '0;
  logic [3:0] extreq = '0;
  logic [3:0] open, pending;
  logic [1:0] floor;
  logic       dir_up, moving;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  elevator_dispatch #(
    .NFLOORS(NF), .MOVE_CYCLES(MV), .DOOR_CYCLES(DR), .IDLE_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .intreq(intreq), .extreq(extreq), .stop(stop),
    .open(open), .floor(floor), .dir_up(dir_up), .moving(moving), .pending(pending)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_open(input logic [3:0] want, input int limit, output int cnt);
    cnt = 0;
    while (open !== want && cnt < limit) begin
      tick();
      cnt++;
    end
  endtask

  // reference model: mode 0 parked, 1 travelling, 2 door open; m_t counts elapsed clocks
  int         m_pos, m_mode, m_t;
  bit         m_up;
  logic [3:0] m_pend;

  function automatic int n_dir(input logic [3:0] c, input int p, input bit up);
    int n = 0;
    for (int i = 0; i < NF; i++)
      if (c[i] && (up ? (i > p) : (i < p))) n++;
    return n;
  endfunction

  task automatic m_scan(input logic [3:0] c);
    m_t = 0;
    if (n_dir(c, m_pos, m_up) > 0)       m_mode = 1;
    else if (n_dir(c, m_pos, !m_up) > 0) begin m_mode = 1; m_up = !m_up; end
    else                                 m_mode = 0;
  endtask

  task automatic model_step(input bit rst, input logic [3:0] r, input bit stp);
    logic [3:0] c;
    c = m_pend | r;
    if (rst) begin
      m_pos = 0; m_mode = 0; m_t = 0; m_up = 1; m_pend = '0;
      return;
    end
    if (!stp) begin
      case (m_mode)
        0: if (c[m_pos]) begin m_mode = 2; m_t = 0; end
           else m_scan(c);
        1: if (m_t < MV - 1) m_t++;
           else begin
             m_pos = m_up ? m_pos + 1 : m_pos - 1;
             if (c[m_pos]) begin m_mode = 2; m_t = 0; end
             else m_scan(c);
           end
        default: if (r[m_pos]) m_t = 0;
                 else if (m_t < DR - 1) m_t++;
                 else m_scan(c);
      endcase
      if (m_pos == 0)      m_up = 1;
      if (m_pos == NF - 1) m_up = 0;
    end
    m_pend = m_pend | r;
    if (m_mode == 2) m_pend[m_pos] = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] ir, er;
    logic       stp;
    int         n;
    logic [1:0] fl;
    logic [3:0] op;
    logic       mv, dr;
    logic [3:0] pd;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int cnt;
    logic [3:0] ir, er;
    bit stp, rst;
    logic [11:0] exp_v;

    //            rst   ir     er     stp   n   fl     op     mv    dr    pd
    tbl[0]  = '{1'b1, 4'hF, 4'h0, 1'b0, 2,  2'd0, 4'h0, 1'b0, 1'b1, 4'h0};
    tbl[1]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1,  2'd0, 4'h0, 1'b0, 1'b1, 4'h0};
    tbl[2]  = '{1'b0, 4'h8, 4'h0, 1'b0, 1,  2'd0, 4'h0, 1'b1, 1'b1, 4'h8};
    tbl[3]  = '{1'b0, 4'h0, 4'h0, 1'b0, 3,  2'd0, 4'h0, 1'b1, 1'b1, 4'h8};
    tbl[4]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1,  2'd1, 4'h0, 1'b1, 1'b1, 4'h8};
    tbl[5]  = '{1'b0, 4'h0, 4'h0, 1'b0, 4,  2'd2, 4'h0, 1'b1, 1'b1, 4'h8};
    tbl[6]  = '{1'b0, 4'h0, 4'h0, 1'b0, 4,  2'd3, 4'h8, 1'b0, 1'b0, 4'h0};
    tbl[7]  = '{1'b0, 4'h0, 4'h0, 1'b0, 2,  2'd3, 4'h8, 1'b0, 1'b0, 4'h0};
    tbl[8]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1,  2'd3, 4'h0, 1'b0, 1'b0, 4'h0};
    tbl[9]  = '{1'b0, 4'h0, 4'h0, 1'b0, 20, 2'd3, 4'h0, 1'b0, 1'b0, 4'h0};
    tbl[10] = '{1'b0, 4'h1, 4'h2, 1'b0, 1,  2'd3, 4'h0, 1'b1, 1'b0, 4'h3};
    tbl[11] = '{1'b0, 4'h0, 4'h0, 1'b0, 7,  2'd2, 4'h0, 1'b1, 1'b0, 4'h3};
    tbl[12] = '{1'b0, 4'h0, 4'h0, 1'b0, 1,  2'd1, 4'h2, 1'b0, 1'b0, 4'h1};
    tbl[13] = '{1'b0, 4'h0, 4'h0, 1'b0, 3,  2'd1, 4'h0, 1'b1, 1'b0, 4'h1};
    tbl[14] = '{1'b0, 4'h0, 4'h0, 1'b0, 4,  2'd0, 4'h1, 1'b0, 1'b1, 4'h0};
    tbl[15] = '{1'b0, 4'h0, 4'h0, 1'b0, 3,  2'd0, 4'h0, 1'b0, 1'b1, 4'h0};

    @(negedge clk);
    for (int r = 0; r < 16; r++) begin
      reset = tbl[r].rst; intreq = tbl[r].ir; extreq = tbl[r].er; stop = tbl[r].stp;
      repeat (tbl[r].n) @(posedge clk);
      @(negedge clk);
      intreq = '0; extreq = '0;
      check($sformatf("row%0d floor", r),   32'(floor),   32'(tbl[r].fl));
      check($sformatf("row%0d open", r),    32'(open),    32'(tbl[r].op));
      check($sformatf("row%0d moving", r),  32'(moving),  32'(tbl[r].mv));
      check($sformatf("row%0d dir_up", r),  32'(dir_up),  32'(tbl[r].dr));
      check($sformatf("row%0d pending", r), 32'(pending), 32'(tbl[r].pd));
    end

    // stop for 5 clocks mid-travel 0->2, call at floor 0 latched while stopped
    intreq = 4'h4; tick(); intreq = '0;
    repeat (5) tick();
    check("stop pre floor", 32'(floor), 32'd1);
    stop = 1'b1; extreq = 4'h1; tick(); extreq = '0;
    check("stop pending latch", 32'(pending), 32'h5);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("stop hold%0d", k), 32'({floor, moving, open}), 32'({2'd1, 1'b1, 4'h0}));
    end
    stop = 1'b0;
    wait_open(4'h4, 20, cnt);
    check("stop arrival delay", 32'(cnt), 32'd3);
    check("stop pending after arrive", 32'(pending), 32'h1);
    wait_open(4'h1, 30, cnt);
    check("stop call served", 32'(cnt), 32'd11);
    check("stop pending cleared", 32'(pending), 32'h0);
    repeat (3) tick();
    check("stop back idle", 32'({moving, open}), 32'h0);

    // door dwell restart at floor 2
    intreq = 4'h4; tick(); intreq = '0;
    wait_open(4'h4, 20, cnt);
    check("dwell arrival", 32'(cnt), 32'd8);
    tick();
    intreq = 4'h4; tick(); intreq = '0;
    check("dwell restart open", 32'(open), 32'h4);
    check("dwell restart pending", 32'(pending), 32'h0);
    tick(); check("dwell hold1", 32'(open), 32'h4);
    tick(); check("dwell hold2", 32'(open), 32'h4);
    tick(); check("dwell close", 32'({moving, open}), 32'h0);

    // reset mid-travel between floors 2 and 1
    intreq = 4'h1; tick(); intreq = '0;
    repeat (2) tick();
    check("pre-reset moving", 32'(moving), 32'd1);
    reset = 1'b1; intreq = 4'hA; tick();
    check("midmove reset", 32'({floor, dir_up, moving, open, pending}), 32'({2'd0, 1'b1, 1'b0, 4'h0, 4'h0}));
    reset = 1'b0; intreq = '0; tick();
    check("post reset idle", 32'({moving, pending}), 32'h0);

    // randomized traffic against the reference model
    reset = 1'b1; model_step(1'b1, 4'h0, 1'b0); tick(); reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      ir = '0; er = '0;
      if ($urandom_range(0, 7) == 0) ir[$urandom_range(0, 3)] = 1'b1;
      if ($urandom_range(0, 7) == 0) er[$urandom_range(0, 3)] = 1'b1;
      stp = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 999) == 0);
      intreq = ir; extreq = er; stop = stp; reset = rst;
      model_step(rst, ir | er, stp);
      tick();
      exp_v = {2'(m_pos), m_up, (m_mode == 1), (m_mode == 2) ? 4'(1 << m_pos) : 4'h0, m_pend};
      check($sformatf("rand cyc%0d", c), 32'({floor, dir_up, moving, open, pending}), 32'(exp_v));
    end
    intreq = '0; extreq = '0; stop = 1'b0; reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
